// File: rtl/product_bcd_conv_if.sv
// Request/result bundle between the multiplier-side producer and the BCD converter.
// The seven-segment pins exist only when SEG7_EN is defined.
interface product_bcd_conv_if;
    logic       done_flag;
    logic [7:0] product_in;
    logic [1:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       bcd_valid;
    logic       busy;
    logic       overrun;
`ifdef SEG7_EN
    logic [6:0] seg_out;
    logic [2:0] dig_sel;
`endif

    modport master (
        output done_flag, product_in,
        input  bcd_hund, bcd_tens, bcd_ones, bcd_valid, busy, overrun
`ifdef SEG7_EN
       ,input  seg_out, dig_sel
`endif
    );

    modport slave (
        input  done_flag, product_in,
        output bcd_hund, bcd_tens, bcd_ones, bcd_valid, busy, overrun
`ifdef SEG7_EN
       ,output seg_out, dig_sel
`endif
    );
endinterface

// File: rtl/product_bcd_conv.sv
// 8-bit product to three BCD digits via sequential double-dabble, one pending slot.
// Optional multiplexed seven-segment driver enabled by defining SEG7_EN.
module product_bcd_conv
`ifdef SEG7_EN
    #(parameter int unsigned REFRESH_W = 12)
`endif
(
    input  logic                 clk,
    input  logic                 rst_n,
    product_bcd_conv_if.slave    io
);
    localparam int unsigned PROD_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned SCR_W  = 9;
    localparam int unsigned SH_W   = 18;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state;
    logic                done_q;
    logic [PROD_W-1:0]   shreg;
    logic [SCR_W-1:0]    scratch;
    logic [CNT_W-1:0]    cnt;
    logic [PROD_W-1:0]   pend;
    logic                pend_full;
    logic [1:0]          hund_q;
    logic [3:0]          tens_q;
    logic [3:0]          ones_q;
    logic                valid_q;
    logic                busy_q;
    logic                overrun_q;

    logic                req_c;
    logic [3:0]          tens_adj_c;
    logic [3:0]          ones_adj_c;
    logic [SH_W-1:0]     sh_c;

    assign req_c = io.done_flag & ~done_q;

    // Add-3 correction then one-bit left shift of {bcd, shreg}; scratch[8] is hundreds bit 0.
    always_comb begin
        tens_adj_c = scratch[7:4];
        ones_adj_c = scratch[3:0];
        if (scratch[7:4] >= 4'd5) tens_adj_c = scratch[7:4] + 4'd3;
        if (scratch[3:0] >= 4'd5) ones_adj_c = scratch[3:0] + 4'd3;
        sh_c = {scratch[8], tens_adj_c, ones_adj_c, shreg, 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            shreg     <= '0;
            scratch   <= '0;
            cnt       <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            hund_q    <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q  <= io.done_flag;
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_c) begin
                        shreg   <= io.product_in;
                        scratch <= '0;
                        cnt     <= '0;
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= sh_c[SH_W-2:PROD_W];
                    shreg   <= sh_c[PROD_W-1:0];
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(7)) begin
                        hund_q  <= sh_c[17:16];
                        tens_q  <= sh_c[15:12];
                        ones_q  <= sh_c[11:8];
                        valid_q <= 1'b1;
                        if (pend_full) begin
                            // Chain straight into the queued value; the freed slot may refill.
                            shreg     <= pend;
                            scratch   <= '0;
                            cnt       <= '0;
                            pend_full <= 1'b0;
                            if (req_c) begin
                                pend      <= io.product_in;
                                pend_full <= 1'b1;
                            end
                        end else if (req_c) begin
                            // Request coincident with completion: queue and consume in one step.
                            shreg   <= io.product_in;
                            scratch <= '0;
                            cnt     <= '0;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (req_c) begin
                        if (pend_full) begin
                            overrun_q <= 1'b1;
                        end else begin
                            pend      <= io.product_in;
                            pend_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign io.bcd_hund  = hund_q;
    assign io.bcd_tens  = tens_q;
    assign io.bcd_ones  = ones_q;
    assign io.bcd_valid = valid_q;
    assign io.busy      = busy_q;
    assign io.overrun   = overrun_q;

`ifdef SEG7_EN
    logic [REFRESH_W-1:0] refresh;
    logic [2:0]           dig_sel_q;
    logic [6:0]           seg_q;
    logic [3:0]           digit_c;
    logic                 blank_c;
    logic [6:0]           seg_c;

    // Pick the scanned digit and blank leading zeros; ones is always lit.
    always_comb begin
        digit_c = ones_q;
        blank_c = 1'b0;
        case (dig_sel_q)
            3'b100: begin
                digit_c = {2'b00, hund_q};
                blank_c = (hund_q == 2'd0);
            end
            3'b010: begin
                digit_c = tens_q;
                blank_c = (hund_q == 2'd0) && (tens_q == 4'd0);
            end
            default: ;
        endcase
        case (digit_c)
            4'd0:    seg_c = 7'h3F;
            4'd1:    seg_c = 7'h06;
            4'd2:    seg_c = 7'h5B;
            4'd3:    seg_c = 7'h4F;
            4'd4:    seg_c = 7'h66;
            4'd5:    seg_c = 7'h6D;
            4'd6:    seg_c = 7'h7D;
            4'd7:    seg_c = 7'h07;
            4'd8:    seg_c = 7'h7F;
            4'd9:    seg_c = 7'h6F;
            default: seg_c = 7'h00;
        endcase
        if (blank_c) seg_c = 7'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh   <= '0;
            dig_sel_q <= 3'b001;
            seg_q     <= '0;
        end else begin
            refresh <= refresh + REFRESH_W'(1);
            if (&refresh) dig_sel_q <= {dig_sel_q[1:0], dig_sel_q[2]};
            seg_q <= seg_c;
        end
    end

    assign io.seg_out = seg_q;
    assign io.dig_sel = dig_sel_q;
`endif

endmodule

// File: tb/tb_product_bcd_conv.sv
// Self-checking bench for product_bcd_conv: vector table, random values, multi-cycle corners.
module tb_product_bcd_conv;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    product_bcd_conv_if bus ();

    product_bcd_conv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        int         hund;
        int         tens;
        int         ones;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to its valid strobe, checking latency and busy span.
    task automatic convert(input logic [7:0] v, input int eh, input int et, input int eo,
                           input string tag);
        int n;
        int busy_cnt;
        bit got;
        bus.product_in = v;
        bus.done_flag  = 1'b1;
        tick();
        bus.done_flag = 1'b0;
        busy_cnt = int'(bus.busy);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (bus.bcd_valid) got = 1'b1;
            else busy_cnt += int'(bus.busy);
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_hund"}, int'(bus.bcd_hund), eh);
        chk({tag, "_tens"}, int'(bus.bcd_tens), et);
        chk({tag, "_ones"}, int'(bus.bcd_ones), eo);
        chk({tag, "_busy_span"}, busy_cnt, 8);
        chk({tag, "_busy_end"}, int'(bus.busy), 0);
        tick();
        chk({tag, "_valid_1cyc"}, int'(bus.bcd_valid), 0);
        tick();
    endtask

    vec_t vecs[6];

    initial begin
        int nvalid;
        int val;
        bit busy_gap;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.done_flag  = 1'b0;
        bus.product_in = 8'd0;

        // Reset state while clock runs
        repeat (3) tick();
        chk("rst_hund", int'(bus.bcd_hund), 0);
        chk("rst_tens", int'(bus.bcd_tens), 0);
        chk("rst_ones", int'(bus.bcd_ones), 0);
        chk("rst_valid", int'(bus.bcd_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        rst_n = 1'b1;
        tick();

        vecs[0] = '{8'hE1, 2, 2, 5};
        vecs[1] = '{8'd0,   0, 0, 0};
        vecs[2] = '{8'd99,  0, 9, 9};
        vecs[3] = '{8'd100, 1, 0, 0};
        vecs[4] = '{8'd255, 2, 5, 5};
        vecs[5] = '{8'd144, 1, 4, 4};
        for (int i = 0; i < 6; i++) begin
            convert(vecs[i].val, vecs[i].hund, vecs[i].tens, vecs[i].ones, $sformatf("vec%0d", i));
            repeat (2) tick();
            chk($sformatf("vec%0d_hold", i), int'(bus.bcd_tens), vecs[i].tens);
        end

        // Random values against decimal arithmetic
        for (int i = 0; i < 30; i++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            convert(r, int'(r) / 100, (int'(r) / 10) % 10, int'(r) % 10, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 3)) tick();
        end

        // Level-held done_flag gives exactly one conversion
        bus.product_in = 8'd36;
        bus.done_flag  = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 29) bus.done_flag = 1'b0;
            if (bus.bcd_valid) nvalid++;
        end
        chk("level_nvalid", nvalid, 1);
        chk("level_hund", int'(bus.bcd_hund), 0);
        chk("level_tens", int'(bus.bcd_tens), 3);
        chk("level_ones", int'(bus.bcd_ones), 6);
        chk("level_overrun", int'(bus.overrun), 0);

        // Back-to-back: 12 at edge k, 200 at k+3 (queued), 7 at k+5 (dropped)
        bus.product_in = 8'd12;
        bus.done_flag  = 1'b1;
        tick();
        bus.done_flag = 1'b0;
        busy_gap = 1'b0;
        nvalid = 0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c <= 15 && !bus.busy) busy_gap = 1'b1;
            if (bus.bcd_valid) begin
                nvalid++;
                val = int'(bus.bcd_hund) * 100 + int'(bus.bcd_tens) * 10 + int'(bus.bcd_ones);
                if (nvalid == 1) begin
                    chk("b2b_first_cycle", c, 8);
                    chk("b2b_first_val", val, 12);
                end else begin
                    chk("b2b_second_cycle", c, 16);
                    chk("b2b_second_val", val, 200);
                end
            end
            bus.done_flag = 1'b0;
            if (c == 2) begin
                bus.product_in = 8'd200;
                bus.done_flag  = 1'b1;
            end
            if (c == 4) begin
                bus.product_in = 8'd7;
                bus.done_flag  = 1'b1;
            end
        end
        chk("b2b_nvalid", nvalid, 2);
        chk("b2b_busy_continuous", int'(busy_gap), 0);
        chk("b2b_overrun", int'(bus.overrun), 1);
        chk("b2b_idle_after", int'(bus.busy), 0);

        // Abort: reset at the 4th shift of 255
        bus.product_in = 8'd255;
        bus.done_flag  = 1'b1;
        tick();
        bus.done_flag = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_overrun", int'(bus.overrun), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.bcd_valid) nvalid++;
        end
        chk("abort_nvalid", nvalid, 0);
        chk("abort_hund", int'(bus.bcd_hund), 0);
        chk("abort_tens", int'(bus.bcd_tens), 0);
        chk("abort_ones", int'(bus.bcd_ones), 0);
        chk("abort_busy_after", int'(bus.busy), 0);
        convert(8'd173, 1, 7, 3, "post_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
